// File: rtl/axis_width_packer_pkg.sv
// Shared helpers for the width packer: ceiling log2 and the layout of one
// FIFO beat entry, packed as {last, strb, data} from MSB to LSB.
package axis_pack_pkg;

   // Ceiling log2. Returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // The data field starts at bit 0 of an entry.
   localparam int DATA_LSB = 0;

   // Entry width: data + one strobe bit per byte + the last flag.
   function automatic int entry_w(input int out_width);
      return out_width + out_width / 8 + 1;
   endfunction

   // The strobe field sits directly above the data field.
   function automatic int strb_lsb(input int out_width);
      return out_width;
   endfunction

   // The last flag is the MSB of the entry.
   function automatic int last_bit(input int out_width);
      return out_width + out_width / 8;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is read
// combinationally from storage, so it is valid whenever count is non-zero.
// Pushes while full and pops while empty are ignored.
module sync_fifo_fwft
   import axis_pack_pkg::*;
#(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic [clog2(DEPTH):0]  count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   // Storage write; contents are don't-care after reset so no reset here.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally at DEPTH; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axis_width_packer.sv
// Packs RATIO narrow input words into one AXI-Stream beat, frames packets
// with tlast every PKT_LEN beats or on flush, and buffers the beats in a
// FWFT FIFO feeding the stream master port.
//
// Handshake: the master port follows strict AXI-Stream valid/ready rules.
// A beat transfers on any rising edge where tvalid and tready are both high.
// tvalid never depends on tready, and once tvalid is high the payload
// (tdata/tstrb/tlast) holds steady until the transfer happens.
module axis_width_packer
   import axis_pack_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int RATIO    = 2,
   parameter int DEPTH    = 16,
   parameter int PKT_LEN  = 256
) (
   input  logic                            m00_axis_aclk,
   input  logic                            m00_axis_aresetn,
   input  logic                            wr_en,
   input  logic [IN_WIDTH-1:0]             wr_data,
   input  logic                            wr_flush,
   output logic                            wr_full,
   output logic                            overflow,
   output logic [clog2(DEPTH):0]           fifo_count,
   output logic [IN_WIDTH*RATIO-1:0]       m00_axis_tdata,
   output logic [IN_WIDTH*RATIO/8-1:0]     m00_axis_tstrb,
   output logic                            m00_axis_tlast,
   output logic                            m00_axis_tvalid,
   input  logic                            m00_axis_tready
);

   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int STRB_W    = OUT_WIDTH / 8;
   localparam int IN_STRB_W = IN_WIDTH / 8;
   localparam int LANE_W    = (RATIO > 1) ? clog2(RATIO) : 1;
   localparam int BCNT_W    = (PKT_LEN > 1) ? clog2(PKT_LEN) : 1;
   localparam int ENTRY_W   = entry_w(OUT_WIDTH);
   localparam int STRB_LSB  = strb_lsb(OUT_WIDTH);
   localparam int LAST_BIT  = last_bit(OUT_WIDTH);

   localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);
   localparam logic [BCNT_W-1:0] BEAT_MAX = BCNT_W'(PKT_LEN - 1);

   logic [LANE_W-1:0]    lane;
   logic [OUT_WIDTH-1:0] acc_data;
   logic [STRB_W-1:0]    acc_strb;
   logic [BCNT_W-1:0]    beat_cnt;

   logic                 accept;
   logic                 flush_ok;
   logic                 close;
   logic                 beat_last;
   logic [OUT_WIDTH-1:0] word_data;
   logic [STRB_W-1:0]    word_strb;
   logic [ENTRY_W-1:0]   push_entry;
   logic [ENTRY_W-1:0]   head_entry;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;

   // A flush is only honoured when the FIFO can take the closing beat.
   assign accept   = wr_en && !wr_full;
   assign flush_ok = wr_flush && !wr_full;

   // Accumulator contents as they would be after including this cycle's word.
   always_comb begin
      word_data = acc_data;
      word_strb = acc_strb;
      for (int i = 0; i < RATIO; i++) begin
         if (accept && (lane == LANE_W'(i))) begin
            word_data[i*IN_WIDTH +: IN_WIDTH]   = wr_data;
            word_strb[i*IN_STRB_W +: IN_STRB_W] = '1;
         end
      end
   end

   // Close the beat on a full accumulator, or on flush when anything is held.
   always_comb begin
      close      = (accept && (lane == LANE_MAX)) || (flush_ok && (|word_strb));
      beat_last  = (beat_cnt == BEAT_MAX) || flush_ok;
      push_entry = {beat_last, word_strb, word_data};
   end

   // Accumulator, lane index, packet beat counter and sticky drop flag.
   always_ff @(posedge m00_axis_aclk) begin
      if (!m00_axis_aresetn) begin
         lane     <= '0;
         acc_data <= '0;
         acc_strb <= '0;
         beat_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (close) begin
            lane     <= '0;
            acc_data <= '0;
            acc_strb <= '0;
            beat_cnt <= beat_last ? '0 : beat_cnt + BCNT_W'(1);
         end else if (accept) begin
            lane     <= lane + LANE_W'(1);
            acc_data <= word_data;
            acc_strb <= word_strb;
         end
         if ((wr_en && wr_full) || (wr_flush && wr_full && (|acc_strb)))
            overflow <= 1'b1;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (m00_axis_aclk),
      .rst_n     (m00_axis_aresetn),
      .push      (close),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wr_full         = fifo_full;
   assign m00_axis_tvalid = !fifo_empty;
   assign pop             = m00_axis_tvalid && m00_axis_tready;

   // Payload is forced to zero while idle so stale storage never shows.
   assign m00_axis_tdata = m00_axis_tvalid ? head_entry[DATA_LSB +: OUT_WIDTH] : '0;
   assign m00_axis_tstrb = m00_axis_tvalid ? head_entry[STRB_LSB +: STRB_W] : '0;
   assign m00_axis_tlast = m00_axis_tvalid && head_entry[LAST_BIT];

endmodule

// File: tb/tb_axis_width_packer.sv
// Bench for axis_width_packer with IN_WIDTH=16, RATIO=2, DEPTH=16, PKT_LEN=4.
// A cycle-level reference model predicts the FIFO contents, occupancy and
// overflow; directed sequences add hand-computed beat values and framing.
module tb_axis_width_packer;

   localparam int IN_W    = 16;
   localparam int RATIO   = 2;
   localparam int OUT_W   = 32;
   localparam int STRB_W  = 4;
   localparam int DEPTH   = 16;
   localparam int PKT_LEN = 4;
   localparam int ENTRY_W = OUT_W + STRB_W + 1;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              wr_en = 1'b0;
   logic              wr_flush = 1'b0;
   logic              tready = 1'b0;
   logic [IN_W-1:0]   wr_data = '0;
   logic              wr_full;
   logic              overflow;
   logic [4:0]        fifo_count;
   logic [OUT_W-1:0]  tdata;
   logic [STRB_W-1:0] tstrb;
   logic              tlast;
   logic              tvalid;

   always #5 clk = ~clk;

   axis_width_packer #(
      .IN_WIDTH (IN_W),
      .RATIO    (RATIO),
      .DEPTH    (DEPTH),
      .PKT_LEN  (PKT_LEN)
   ) dut (
      .m00_axis_aclk    (clk),
      .m00_axis_aresetn (rstn),
      .wr_en            (wr_en),
      .wr_data          (wr_data),
      .wr_flush         (wr_flush),
      .wr_full          (wr_full),
      .overflow         (overflow),
      .fifo_count       (fifo_count),
      .m00_axis_tdata   (tdata),
      .m00_axis_tstrb   (tstrb),
      .m00_axis_tlast   (tlast),
      .m00_axis_tvalid  (tvalid),
      .m00_axis_tready  (tready)
   );

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;
   bit checks_on = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [ENTRY_W-1:0] exp_q[$];
   logic [OUT_W-1:0]   m_acc_data;
   logic [STRB_W-1:0]  m_acc_strb;
   int                 m_lane;
   int                 m_beat;
   bit                 m_ovf;

   always @(posedge clk) begin
      logic [OUT_W-1:0]  nd;
      logic [STRB_W-1:0] ns;
      bit full, acc, close, last;
      if (!rstn) begin
         m_acc_data = '0;
         m_acc_strb = '0;
         m_lane     = 0;
         m_beat     = 0;
         m_ovf      = 1'b0;
         exp_q.delete();
      end else begin
         full = (exp_q.size() == DEPTH);
         if (exp_q.size() != 0 && tready) void'(exp_q.pop_front());
         nd  = m_acc_data;
         ns  = m_acc_strb;
         acc = wr_en && !full;
         if (acc) begin
            nd[m_lane*IN_W +: IN_W] = wr_data;
            ns[m_lane*2 +: 2]       = 2'b11;
         end
         if (wr_en && full) m_ovf = 1'b1;
         if (wr_flush && full && m_acc_strb != 0) m_ovf = 1'b1;
         close = (acc && m_lane == RATIO - 1) || (wr_flush && !full && ns != 0);
         if (close) begin
            last = (m_beat == PKT_LEN - 1) || (wr_flush && !full);
            exp_q.push_back({last, ns, nd});
            m_beat = last ? 0 : m_beat + 1;
            m_lane = 0;
            nd     = '0;
            ns     = '0;
         end else if (acc) begin
            m_lane = m_lane + 1;
         end
         m_acc_data = nd;
         m_acc_strb = ns;
      end
   end

   // Beats seen leaving the DUT, for directed framing/order checks.
   bit               pop_last_q[$];
   logic [OUT_W-1:0] pop_data_q[$];

   // Sample mid-cycle: compare the DUT against the model every cycle.
   always @(negedge clk) begin
      if (checks_on) begin
         check("tvalid", tvalid, exp_q.size() != 0);
         check("fifo_count", fifo_count, exp_q.size());
         check("wr_full", wr_full, exp_q.size() == DEPTH);
         check("overflow", overflow, m_ovf);
         check("count_le_depth", fifo_count <= DEPTH, 1);
         if (exp_q.size() != 0) check("head", {tlast, tstrb, tdata}, exp_q[0]);
         if (tvalid && tready) begin
            pop_last_q.push_back(tlast);
            pop_data_q.push_back(tdata);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      rstn     = 1'b0;
      wr_en    = 1'b0;
      wr_flush = 1'b0;
      step();
      rstn = 1'b1;
   endtask

   task automatic write_word(input logic [IN_W-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic clear_log();
      pop_last_q.delete();
      pop_data_q.delete();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_tvalid"}, tvalid, 0);
      check({tag, "_tdata"}, tdata, 0);
      check({tag, "_tstrb"}, tstrb, 0);
      check({tag, "_tlast"}, tlast, 0);
      check({tag, "_count"}, fifo_count, 0);
      check({tag, "_full"}, wr_full, 0);
      check({tag, "_ovf"}, overflow, 0);
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] lv;
      int         words;

      do_reset();
      checks_on = 1'b1;
      check_zero_outputs("reset");

      // Basic packing: two words form one beat, visible one cycle later.
      tready = 1'b1;
      write_word(16'h1111);
      check("basic_not_yet", tvalid, 0);
      write_word(16'h2222);
      check("basic_tvalid", tvalid, 1);
      check("basic_tdata", tdata, 32'h2222_1111);
      check("basic_tstrb", tstrb, 4'hF);
      check("basic_tlast", tlast, 0);
      step();
      check("basic_drained", tvalid, 0);

      // Packet framing: 16 words -> 8 beats, tlast on beats 3 and 7.
      do_reset();
      clear_log();
      tready = 1'b1;
      for (int i = 0; i < 16; i++) write_word(16'h0010 + 16'(i));
      idle(4);
      check("frame_beats", pop_data_q.size(), 8);
      lv = '0;
      foreach (pop_last_q[k]) if (k < 8) lv[k] = pop_last_q[k];
      check("frame_lasts", lv, 8'b1000_1000);
      check("frame_beat3", pop_data_q[3], 32'h0017_0016);
      check("frame_beat7", pop_data_q[7], 32'h001F_001E);

      // Partial flush with a word in the same cycle.
      do_reset();
      tready   = 1'b0;
      wr_flush = 1'b1;
      write_word(16'hABCD);
      wr_flush = 1'b0;
      check("flush_tdata", tdata, 32'h0000_ABCD);
      check("flush_tstrb", tstrb, 4'h3);
      check("flush_tlast", tlast, 1);
      check("flush_count", fifo_count, 1);
      clear_log();
      tready = 1'b1;
      for (int i = 0; i < 8; i++) write_word(16'h0200 + 16'(i));
      idle(4);
      check("flush_beats", pop_last_q.size(), 5);
      lv = '0;
      foreach (pop_last_q[k]) if (k < 8) lv[k] = pop_last_q[k];
      check("flush_lasts", lv, 8'b0001_0001);

      // Backpressure and overflow: 34 words into a 16-beat FIFO.
      do_reset();
      tready = 1'b0;
      for (int i = 0; i < 34; i++) write_word(16'h0100 + 16'(i));
      check("bp_count", fifo_count, 16);
      check("bp_full", wr_full, 1);
      check("bp_ovf", overflow, 1);
      check("bp_head", tdata, 32'h0101_0100);
      clear_log();
      tready = 1'b1;
      idle(20);
      check("bp_beats", pop_data_q.size(), 16);
      check("bp_first", pop_data_q[0], 32'h0101_0100);
      check("bp_last", pop_data_q[15], 32'h011F_011E);
      check("bp_ovf_sticky", overflow, 1);
      wr_flush = 1'b1;
      step();
      wr_flush = 1'b0;
      check("bp_empty_flush", fifo_count, 0);

      // Reset mid-packet discards the partial word.
      do_reset();
      tready = 1'b1;
      write_word(16'hDEAD);
      rstn = 1'b0;
      step();
      check_zero_outputs("midrst");
      rstn = 1'b1;
      write_word(16'h0001);
      write_word(16'h0002);
      check("midrst_tdata", tdata, 32'h0002_0001);
      check("midrst_tstrb", tstrb, 4'hF);
      check("midrst_tlast", tlast, 0);

      // Random streaming with toggling backpressure and occasional flushes.
      do_reset();
      words = 0;
      while (words < 1024) begin
         tready   = 1'($urandom_range(0, 1));
         wr_en    = ($urandom_range(0, 3) != 0);
         wr_flush = ($urandom_range(0, 15) == 0);
         wr_data  = 16'($urandom_range(0, 65535));
         if (wr_en) words++;
         step();
      end
      wr_en    = 1'b0;
      wr_flush = 1'b1;
      tready   = 1'b1;
      step();
      wr_flush = 1'b0;
      for (int k = 0; k < 200 && tvalid; k++) step();
      check("drain_done", tvalid, 0);

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
